// File: rtl/icmp_pkg.sv
// Shared ICMP definitions: message types, header length, TX engine states and
// the checksum seed helper used by the echo generator.
package icmp_pkg;

    localparam logic [7:0] ICMP_TYPE_ECHO_REPLY = 8'd0;
    localparam logic [7:0] ICMP_TYPE_ECHO_REQ   = 8'd8;
    localparam int         ICMP_HDR_LEN         = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CSUM,
        FOLD,
        SEND
    } icmp_state_e;

    // Header words that carry data: {type,code=0}, identifier, sequence.
    // The checksum field itself counts as zero.
    function automatic logic [31:0] csum_seed(input logic [7:0]  typ,
                                              input logic [15:0] ident,
                                              input logic [15:0] seq);
        return {16'h0000, typ, 8'h00} + {16'h0000, ident} + {16'h0000, seq};
    endfunction

endpackage

// File: rtl/icmp_csum16.sv
// Serial ones-complement checksum accumulator: seed, add one 16-bit word per
// cycle, fold the carries back in, then read the inverted result.
module icmp_csum16 (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        seed_i,
    input  logic [31:0] seed_val_i,
    input  logic        add_i,
    input  logic [15:0] word_i,
    input  logic        fold_i,
    output logic [15:0] result_o
);

    logic [31:0] acc_q, acc_d;

    always_comb begin
        acc_d = acc_q;
        if (seed_i) begin
            acc_d = seed_val_i;
        end else if (add_i) begin
            acc_d = acc_q + {16'h0000, word_i};
        end else if (fold_i) begin
            acc_d = {16'h0000, acc_q[31:16]} + {16'h0000, acc_q[15:0]};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign result_o = ~acc_q[15:0];

endmodule

// File: rtl/icmp_echo_tx.sv
// ICMP echo reply/request frame generator feeding the IP TX framer.
// Optional counters (reply/request/drop) are built when ICMP_ECHO_TX_STATS_EN is defined.
module icmp_echo_tx
    import icmp_pkg::*;
#(
    parameter int          P_DATA_LEN  = 32,
    parameter logic [15:0] P_IDENT     = 16'h0001,
    parameter logic [7:0]  P_FILL_BASE = 8'h00
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_trig_reply,
    input  logic [15:0] i_trig_id,
    input  logic [15:0] i_trig_seq,
    input  logic        i_active_req,
    input  logic [15:0] i_active_seq,
    output logic [7:0]  o_icmp_data,
    output logic [15:0] o_icmp_len,
    output logic        o_icmp_last,
    output logic        o_icmp_valid,
    input  logic        i_icmp_ready,
    output logic        o_busy
`ifdef ICMP_ECHO_TX_STATS_EN
    ,
    output logic [15:0] o_reply_cnt,
    output logic [15:0] o_req_cnt,
    output logic [15:0] o_drop_cnt
`endif
);

    localparam int TOTAL  = ICMP_HDR_LEN + P_DATA_LEN;
    localparam int NWORDS = (P_DATA_LEN + 1) / 2;
    localparam int BW     = $clog2(TOTAL + 1);
    localparam int WW     = $clog2(NWORDS + 1);

    icmp_state_e state_q, state_d;
    logic          is_reply_q, is_reply_d;
    logic [7:0]    type_q, type_d;
    logic [15:0]   ident_q, ident_d;
    logic [15:0]   seq_q, seq_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic          fold_q, fold_d;
    logic [BW-1:0] bcnt_q, bcnt_d;

    logic        rep_pend_q, req_pend_q;
    logic [15:0] rep_id_q, rep_seq_q, req_seq_q;

    logic        consume_rep, consume_req, sending, xfer, last_byte;
    logic        csum_seed_en, csum_add, csum_fold;
    logic [31:0] csum_seed_val;
    logic [15:0] csum_word, csum_result;
    logic [15:0] hi_idx, pidx;
    logic [7:0]  word_lo, tx_byte;

    assign sending     = (state_q == SEND);
    assign xfer        = sending && i_icmp_ready;
    assign last_byte   = (bcnt_q == BW'(TOTAL - 1));
    assign consume_rep = (state_q == LOAD) && is_reply_q;
    assign consume_req = (state_q == LOAD) && !is_reply_q;

    // A pulse arriving in the same cycle the slot is consumed stays pending.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rep_pend_q <= 1'b0;
            rep_id_q   <= '0;
            rep_seq_q  <= '0;
            req_pend_q <= 1'b0;
            req_seq_q  <= '0;
        end else begin
            if (i_trig_reply) begin
                rep_pend_q <= 1'b1;
                rep_id_q   <= i_trig_id;
                rep_seq_q  <= i_trig_seq;
            end else if (consume_rep) begin
                rep_pend_q <= 1'b0;
            end
            if (i_active_req) begin
                req_pend_q <= 1'b1;
                req_seq_q  <= i_active_seq;
            end else if (consume_req) begin
                req_pend_q <= 1'b0;
            end
        end
    end

    // Payload word j = {byte 2j, byte 2j+1}; a missing odd tail byte reads as zero.
    assign hi_idx    = 16'(wcnt_q) << 1;
    assign word_lo   = ((hi_idx + 16'd1) < 16'(P_DATA_LEN)) ? (P_FILL_BASE + hi_idx[7:0] + 8'd1) : 8'h00;
    assign csum_word = {P_FILL_BASE + hi_idx[7:0], word_lo};

    always_comb begin
        state_d       = state_q;
        is_reply_d    = is_reply_q;
        type_d        = type_q;
        ident_d       = ident_q;
        seq_d         = seq_q;
        wcnt_d        = wcnt_q;
        fold_d        = fold_q;
        bcnt_d        = bcnt_q;
        csum_seed_en  = 1'b0;
        csum_seed_val = '0;
        csum_add      = 1'b0;
        csum_fold     = 1'b0;
        case (state_q)
            IDLE: begin
                bcnt_d = '0;
                if (rep_pend_q) begin
                    state_d    = LOAD;
                    is_reply_d = 1'b1;
                end else if (req_pend_q) begin
                    state_d    = LOAD;
                    is_reply_d = 1'b0;
                end
            end
            LOAD: begin
                type_d        = is_reply_q ? ICMP_TYPE_ECHO_REPLY : ICMP_TYPE_ECHO_REQ;
                ident_d       = is_reply_q ? rep_id_q : P_IDENT;
                seq_d         = is_reply_q ? rep_seq_q : req_seq_q;
                csum_seed_en  = 1'b1;
                csum_seed_val = csum_seed(type_d, ident_d, seq_d);
                wcnt_d        = '0;
                state_d       = CSUM;
            end
            CSUM: begin
                csum_add = 1'b1;
                if (wcnt_q == WW'(NWORDS - 1)) begin
                    fold_d  = 1'b0;
                    state_d = FOLD;
                end else begin
                    wcnt_d = wcnt_q + WW'(1);
                end
            end
            FOLD: begin
                csum_fold = 1'b1;
                fold_d    = 1'b1;
                if (fold_q) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (last_byte) begin
                        state_d = IDLE;
                    end else begin
                        bcnt_d = bcnt_q + BW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            is_reply_q <= 1'b0;
            type_q     <= '0;
            ident_q    <= '0;
            seq_q      <= '0;
            wcnt_q     <= '0;
            fold_q     <= 1'b0;
            bcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            is_reply_q <= is_reply_d;
            type_q     <= type_d;
            ident_q    <= ident_d;
            seq_q      <= seq_d;
            wcnt_q     <= wcnt_d;
            fold_q     <= fold_d;
            bcnt_q     <= bcnt_d;
        end
    end

    icmp_csum16 u_csum (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .seed_i     (csum_seed_en),
        .seed_val_i (csum_seed_val),
        .add_i      (csum_add),
        .word_i     (csum_word),
        .fold_i     (csum_fold),
        .result_o   (csum_result)
    );

    // Stream handshake: a byte moves on valid && ready; while valid && !ready the
    // byte index is frozen, so data/last hold, and valid stays high until the last byte moves.
    assign pidx = 16'(bcnt_q) - 16'(ICMP_HDR_LEN);

    always_comb begin
        case (bcnt_q)
            BW'(0):  tx_byte = type_q;
            BW'(1):  tx_byte = 8'h00;
            BW'(2):  tx_byte = csum_result[15:8];
            BW'(3):  tx_byte = csum_result[7:0];
            BW'(4):  tx_byte = ident_q[15:8];
            BW'(5):  tx_byte = ident_q[7:0];
            BW'(6):  tx_byte = seq_q[15:8];
            BW'(7):  tx_byte = seq_q[7:0];
            default: tx_byte = P_FILL_BASE + pidx[7:0];
        endcase
    end

    assign o_icmp_data  = sending ? tx_byte : 8'h00;
    assign o_icmp_valid = sending;
    assign o_icmp_last  = sending && last_byte;
    assign o_icmp_len   = 16'(TOTAL);
    // Pending work in IDLE also counts as busy, so back-to-back frames keep it high.
    assign o_busy       = (state_q != IDLE) || rep_pend_q || req_pend_q;

`ifdef ICMP_ECHO_TX_STATS_EN
    logic [15:0] reply_cnt_q, req_cnt_q, drop_cnt_q;
    logic        drop_rep, drop_req;

    assign drop_rep = i_trig_reply && rep_pend_q && !consume_rep;
    assign drop_req = i_active_req && req_pend_q && !consume_req;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            reply_cnt_q <= '0;
            req_cnt_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (xfer && last_byte && is_reply_q) begin
                reply_cnt_q <= reply_cnt_q + 16'd1;
            end
            if (xfer && last_byte && !is_reply_q) begin
                req_cnt_q <= req_cnt_q + 16'd1;
            end
            drop_cnt_q <= drop_cnt_q + 16'(drop_rep) + 16'(drop_req);
        end
    end

    assign o_reply_cnt = reply_cnt_q;
    assign o_req_cnt   = req_cnt_q;
    assign o_drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_icmp_echo_tx.sv
// Bench for icmp_echo_tx: frame-level reference model with pending slots and an
// expected byte queue, randomized pulses and backpressure, plus directed frames.
module tb_icmp_echo_tx;

    localparam int          N     = 32;
    localparam int          H     = (N + 1) / 2;
    localparam logic [15:0] IDENT = 16'h0001;
    localparam logic [7:0]  BASE  = 8'h00;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        trig_reply, active_req, ready;
    logic [15:0] trig_id, trig_seq, active_seq;
    logic [7:0]  data;
    logic [15:0] len;
    logic        last, valid, busy;

    logic        t1_rp, t1_ap, t1_ready;
    logic [15:0] t1_id, t1_seq, t1_aseq;
    logic [7:0]  d1_data;
    logic [15:0] d1_len;
    logic        d1_last, d1_valid, d1_busy;

`ifdef ICMP_ECHO_TX_STATS_EN
    logic [15:0] reply_cnt, req_cnt, drop_cnt;
    logic [15:0] d1_reply_cnt, d1_req_cnt, d1_drop_cnt;
`endif

    icmp_echo_tx #(.P_DATA_LEN(N), .P_IDENT(IDENT), .P_FILL_BASE(BASE)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_trig_reply(trig_reply), .i_trig_id(trig_id), .i_trig_seq(trig_seq),
        .i_active_req(active_req), .i_active_seq(active_seq),
        .o_icmp_data(data), .o_icmp_len(len), .o_icmp_last(last),
        .o_icmp_valid(valid), .i_icmp_ready(ready), .o_busy(busy)
`ifdef ICMP_ECHO_TX_STATS_EN
        , .o_reply_cnt(reply_cnt), .o_req_cnt(req_cnt), .o_drop_cnt(drop_cnt)
`endif
    );

    icmp_echo_tx #(.P_DATA_LEN(1), .P_IDENT(16'h0001), .P_FILL_BASE(8'hAB)) dut1 (
        .i_clk(clk), .i_rst(rst),
        .i_trig_reply(t1_rp), .i_trig_id(t1_id), .i_trig_seq(t1_seq),
        .i_active_req(t1_ap), .i_active_seq(t1_aseq),
        .o_icmp_data(d1_data), .o_icmp_len(d1_len), .o_icmp_last(d1_last),
        .o_icmp_valid(d1_valid), .i_icmp_ready(t1_ready), .o_busy(d1_busy)
`ifdef ICMP_ECHO_TX_STATS_EN
        , .o_reply_cnt(d1_reply_cnt), .o_req_cnt(d1_req_cnt), .o_drop_cnt(d1_drop_cnt)
`endif
    );

    // Scoreboard entries: {is_reply, last, byte}
    logic [9:0]  exp_q[$];
    logic [7:0]  cap_q[$];
    bit          m_free, m_rep_pend, m_req_pend;
    logic [15:0] m_rep_id, m_rep_seq, m_req_seq;
    int          m_rep_cnt, m_req_cnt, m_drop;
    int          n_cmp, n_fail;
    bit          rdy_rand, rnd_pulse, waiting;
    int          wait_cnt;
    logic        prev_valid, prev_ready, prev_last;
    logic [7:0]  prev_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: expected event did not occur (t=%0t)", name, $time);
    endtask

    // Internet checksum of the whole message with its checksum field zeroed.
    function automatic logic [15:0] ref_csum(input logic [7:0] typ, input logic [15:0] id,
                                             input logic [15:0] seq, input int plen,
                                             input logic [7:0] base);
        logic [7:0]  msg[$];
        logic [31:0] s;
        msg = '{typ, 8'h00, 8'h00, 8'h00, id[15:8], id[7:0], seq[15:8], seq[7:0]};
        for (int k = 0; k < plen; k++) msg.push_back(8'(base + k));
        if (msg.size() % 2 != 0) msg.push_back(8'h00);
        s = 0;
        for (int i = 0; i < msg.size(); i += 2) s += {16'h0000, msg[i], msg[i+1]};
        while (s[31:16] != 0) s = {16'h0000, s[31:16]} + {16'h0000, s[15:0]};
        return ~s[15:0];
    endfunction

    task automatic push_frame(input bit is_rep, input logic [15:0] id, input logic [15:0] seq);
        logic [7:0]  typ;
        logic [15:0] ck;
        logic [7:0]  b;
        typ = is_rep ? 8'd0 : 8'd8;
        ck  = ref_csum(typ, id, seq, N, BASE);
        for (int i = 0; i < N + 8; i++) begin
            case (i)
                0: b = typ;
                1: b = 8'h00;
                2: b = ck[15:8];
                3: b = ck[7:0];
                4: b = id[15:8];
                5: b = id[7:0];
                6: b = seq[15:8];
                7: b = seq[7:0];
                default: b = 8'(BASE + i - 8);
            endcase
            exp_q.push_back({is_rep, (i == N + 7), b});
        end
    endtask

    task automatic try_pop();
        if (m_free && m_rep_pend) begin
            push_frame(1'b1, m_rep_id, m_rep_seq);
            m_rep_pend = 0;
            m_free     = 0;
        end else if (m_free && m_req_pend) begin
            push_frame(1'b0, IDENT, m_req_seq);
            m_req_pend = 0;
            m_free     = 0;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_free = 1; m_rep_pend = 0; m_req_pend = 0;
        m_rep_cnt = 0; m_req_cnt = 0; m_drop = 0;
        waiting = 0; wait_cnt = 0;
        prev_valid = 0; prev_ready = 1; prev_last = 0; prev_data = 0;
    endtask

    // One clock of stimulus and checking, done at the falling edge.
    task automatic cycle(input bit rp_in, input logic [15:0] rid_in, input logic [15:0] rseq_in,
                         input bit ap_in, input logic [15:0] aseq_in);
        bit          free_top, rdy, rp, ap;
        logic [15:0] rid, rseq, aseq;
        logic [9:0]  e;
        rp = rp_in; rid = rid_in; rseq = rseq_in; ap = ap_in; aseq = aseq_in;
        @(negedge clk);
        free_top = m_free;
        check("len", len, 32'(N + 8));
        check("busy", busy, !m_free);
        if (prev_valid && !prev_ready) begin
            check("stall_valid", valid, 1);
            check("stall_data", data, prev_data);
            check("stall_last", last, prev_last);
        end
        if (waiting) begin
            wait_cnt++;
            if (valid) begin
                check("first_valid_latency", wait_cnt, H + 5);
                waiting = 0;
            end else if (wait_cnt > 400) begin
                fail_now("first_valid_timeout");
                waiting = 0;
            end
        end
        rdy   = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        ready = rdy;
        if (valid && rdy) begin
            cap_q.push_back(data);
            if (exp_q.size() == 0) begin
                fail_now("byte_without_expected_frame");
            end else begin
                e = exp_q.pop_front();
                check("data", data, e[7:0]);
                check("last", last, e[8]);
                if (e[8]) begin
                    m_free = 1;
                    if (e[9]) m_rep_cnt++;
                    else      m_req_cnt++;
                end
            end
        end
        if (rnd_pulse) begin
            rp   = (free_top || valid) && ($urandom_range(0, 11) == 0);
            ap   = (free_top || valid) && ($urandom_range(0, 11) == 0);
            rid  = 16'($urandom);
            rseq = 16'($urandom);
            aseq = 16'($urandom);
        end
        trig_reply = rp; trig_id = rid; trig_seq = rseq;
        active_req = ap; active_seq = aseq;
        if (rp) begin
            if (m_rep_pend) m_drop++;
            m_rep_pend = 1; m_rep_id = rid; m_rep_seq = rseq;
        end
        if (ap) begin
            if (m_req_pend) m_drop++;
            m_req_pend = 1; m_req_seq = aseq;
        end
        try_pop();
        if (free_top && !m_free) begin
            waiting  = 1;
            wait_cnt = 0;
        end
        prev_valid = valid; prev_ready = rdy; prev_data = data; prev_last = last;
    endtask

    task automatic run_idle(input int max_cycles);
        bit done;
        done = 0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            cycle(0, 0, 0, 0, 0);
            done = m_free && (exp_q.size() == 0);
        end
        if (!done) fail_now("drain_timeout");
        cycle(0, 0, 0, 0, 0);
    endtask

    logic [7:0] hdr_rep[8]  = '{8'h00, 8'h00, 8'h0E, 8'hF9, 8'h00, 8'h01, 8'h00, 8'h05};
    logic [7:0] hdr_req[8]  = '{8'h08, 8'h00, 8'h06, 8'hFD, 8'h00, 8'h01, 8'h00, 8'h01};
    logic [7:0] frame_1b[9] = '{8'h00, 8'h00, 8'h54, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'hAB};

    initial begin
        logic [7:0] d1_cap[$];
        int         last_idx;
        bit         seen;
        n_cmp = 0; n_fail = 0;
        rdy_rand = 0; rnd_pulse = 0;
        model_reset();
        rst = 1; ready = 1;
        trig_reply = 0; trig_id = 0; trig_seq = 0; active_req = 0; active_seq = 0;
        t1_rp = 0; t1_id = 0; t1_seq = 0; t1_ap = 0; t1_aseq = 0; t1_ready = 1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data", data, 0);
        check("rst_valid", valid, 0);
        check("rst_last", last, 0);
        check("rst_busy", busy, 0);
        check("rst_valid_1b", d1_valid, 0);
        rst = 0;

        // Pin the reference checksum against hand-computed values
        check("model_ck_reply", ref_csum(8'd0, 16'h0001, 16'h0005, 32, 8'h00), 16'h0EF9);
        check("model_ck_req", ref_csum(8'd8, 16'h0001, 16'h0001, 32, 8'h00), 16'h06FD);
        check("model_ck_len1", ref_csum(8'd0, 16'h0000, 16'h0000, 1, 8'hAB), 16'h54FF);

        // Default reply, ready held high
        cap_q.delete();
        cycle(1, 16'h0001, 16'h0005, 0, 0);
        run_idle(200);
        check("reply_len", cap_q.size(), 40);
        for (int i = 0; i < 8; i++) check($sformatf("reply_hdr%0d", i), cap_q[i], hdr_rep[i]);
        if (cap_q.size() == 40) check("reply_tail", cap_q[39], 8'h1F);

        // Default request
        cap_q.delete();
        cycle(0, 0, 0, 1, 16'h0001);
        run_idle(200);
        check("req_len", cap_q.size(), 40);
        for (int i = 0; i < 8; i++) check($sformatf("req_hdr%0d", i), cap_q[i], hdr_req[i]);

        // Simultaneous reply and request: reply first, request right after
        cap_q.delete();
        cycle(1, 16'h1234, 16'h0005, 1, 16'h0001);
        run_idle(400);
        check("both_len", cap_q.size(), 80);
        if (cap_q.size() == 80) begin
            check("both_first_type", cap_q[0], 8'h00);
            check("both_second_type", cap_q[40], 8'h08);
        end

        // Random backpressure on a single reply
        cap_q.delete();
        rdy_rand = 1;
        cycle(1, 16'h0001, 16'h0005, 0, 0);
        run_idle(600);
        check("stall_frame_len", cap_q.size(), 40);
        rdy_rand = 0;

        // Two reply pulses during SEND: only the latest survives
        cap_q.delete();
        cycle(1, 16'h0001, 16'h0003, 0, 0);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            cycle(0, 0, 0, 0, 0);
            seen = valid;
        end
        if (!seen) fail_now("send_start_timeout");
        cycle(1, 16'h0001, 16'h0007, 0, 0);
        repeat (3) cycle(0, 0, 0, 0, 0);
        cycle(1, 16'h0001, 16'h0009, 0, 0);
        run_idle(400);
        check("overwrite_len", cap_q.size(), 80);
        if (cap_q.size() == 80) check("overwrite_seq", {cap_q[46], cap_q[47]}, 16'h0009);
`ifdef ICMP_ECHO_TX_STATS_EN
        check("drop_cnt_one", drop_cnt, 1);
`endif

        // Randomized pulses and backpressure
        rdy_rand = 1; rnd_pulse = 1;
        repeat (1500) cycle(0, 0, 0, 0, 0);
        rnd_pulse = 0;
        run_idle(3000);
        rdy_rand = 0;
`ifdef ICMP_ECHO_TX_STATS_EN
        check("reply_cnt", reply_cnt, 16'(m_rep_cnt));
        check("req_cnt", req_cnt, 16'(m_req_cnt));
        check("drop_cnt", drop_cnt, 16'(m_drop));
`endif

        // One-byte payload instance with a non-zero fill base
        @(negedge clk);
        t1_rp = 1; t1_id = 16'h0000; t1_seq = 16'h0000;
        @(negedge clk);
        t1_rp = 0;
        last_idx = -1; seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (d1_valid) begin
                d1_cap.push_back(d1_data);
                if (d1_last) begin
                    last_idx = d1_cap.size() - 1;
                    seen = 1;
                end
            end
        end
        if (!seen) fail_now("len1_last_timeout");
        check("len1_olen", d1_len, 9);
        check("len1_count", d1_cap.size(), 9);
        check("len1_last_idx", last_idx, 8);
        for (int i = 0; i < 9 && i < d1_cap.size(); i++)
            check($sformatf("len1_byte%0d", i), d1_cap[i], frame_1b[i]);
        @(negedge clk);
        check("len1_valid_drop", d1_valid, 0);

        // Reset in the middle of a frame, then a clean frame
        cap_q.delete();
        cycle(1, 16'h0001, 16'h0005, 0, 0);
        for (int i = 0; i < 100 && cap_q.size() < 5; i++) cycle(0, 0, 0, 0, 0);
        if (cap_q.size() < 5) fail_now("midframe_start_timeout");
        @(negedge clk);
        rst = 1;
        #1;
        check("midrst_data", data, 0);
        check("midrst_valid", valid, 0);
        check("midrst_last", last, 0);
        check("midrst_busy", busy, 0);
        model_reset();
        @(negedge clk);
        rst = 0;
        cap_q.delete();
        cycle(1, 16'h00AA, 16'h0042, 0, 0);
        run_idle(200);
        check("post_rst_len", cap_q.size(), 40);
        if (cap_q.size() == 40) check("post_rst_seq", cap_q[7], 8'h42);
`ifdef ICMP_ECHO_TX_STATS_EN
        check("post_rst_reply_cnt", reply_cnt, 16'(m_rep_cnt));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
